// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the two requester channels (instruction fetch "i_*",
//               load/store "d_*") and the shared word-memory bus "mem_*"
//               seen by mem_arbiter.
//               slave  : arbiter side (takes requests, drives memory bus)
//               master : requester/memory side (drives requests, mem_RD)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
    // Instruction-fetch channel (read-only)
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        i_err;
    // Load/store channel
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    // Shared single-port word memory
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_We;
    logic [31:0] mem_RD;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_RD,
        output i_gnt, i_done, i_rdata, i_err,
        output d_gnt, d_done, d_rdata, d_err,
        output mem_A, mem_WD, mem_We
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_RD,
        input  i_gnt, i_done, i_rdata, i_err,
        input  d_gnt, d_done, d_rdata, d_err,
        input  mem_A, mem_WD, mem_We
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter/sequencer in front of a single-port
//               word memory (sync write, combinational read). Grants one
//               requester in IDLE, drives the memory for one SERVE cycle and
//               returns a registered one-cycle done pulse in RESP.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - mem_arbiter_if.slave (i_*, d_*, mem_* signals)
// Parameters  : MEM_WORDS - memory depth in words; index >= MEM_WORDS is
//                           flagged as an error and never written
//               PRIO_MODE - 0: round-robin, 1: D always wins a tie
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int MEM_WORDS = 16000,
    parameter int PRIO_MODE = 0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [31:0] c_MEM_WORDS = 32'(MEM_WORDS);
    localparam logic        c_D_PRIO    = (PRIO_MODE == 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [29:0] r_word;      // latched word index (byte offset dropped)
    logic        r_we;
    logic [31:0] r_wdata;
    logic        r_owner_d;   // 1: current access belongs to D
    logic        r_last_d;    // 1: D won the most recent arbitration

    logic        r_i_done, r_i_err, r_d_done, r_d_err;
    logic [31:0] r_i_rdata, r_d_rdata;

    logic        w_pick_d;
    logic        w_i_gnt, w_d_gnt;
    logic        w_serve;
    logic        w_oor;
    logic [31:0] w_rdata_cap;

    // Byte-offset bits are deliberately ignored.
    logic w_unused_ok;
    assign w_unused_ok = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

    // D wins when alone, or on a tie when it has priority or I won last time.
    assign w_pick_d = bus.d_req & (~bus.i_req | c_D_PRIO | ~r_last_d);

    assign w_serve     = (r_state == ST_SERVE);
    assign w_oor       = {2'b00, r_word} >= c_MEM_WORDS;
    assign w_rdata_cap = (r_we | w_oor) ? 32'd0 : bus.mem_RD;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_i_gnt      = 1'b0;
        w_d_gnt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Grants are suppressed while rst is high: nothing would
                // be latched, so the requester must keep waiting.
                if (!rst && (bus.i_req || bus.d_req)) begin
                    w_d_gnt      = w_pick_d;
                    w_i_gnt      = ~w_pick_d;
                    w_state_next = ST_SERVE;
                end
            end
            ST_SERVE: w_state_next = ST_RESP;
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and arbitration history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_owner_d <= 1'b0;
            r_last_d  <= 1'b1;   // so I wins the first round-robin tie
        end else if (w_i_gnt || w_d_gnt) begin
            r_word    <= w_pick_d ? bus.d_addr[31:2] : bus.i_addr[31:2];
            r_we      <= w_pick_d & bus.d_we;
            r_wdata   <= w_pick_d ? bus.d_wdata : 32'd0;
            r_owner_d <= w_pick_d;
            r_last_d  <= w_pick_d;
        end
    end

    // ------------------------------------------------------------------
    // Response registers: done/err live for the RESP cycle only, rdata
    // persists until the owner's next response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_done  <= 1'b0;
            r_i_err   <= 1'b0;
            r_i_rdata <= '0;
            r_d_done  <= 1'b0;
            r_d_err   <= 1'b0;
            r_d_rdata <= '0;
        end else begin
            r_i_done <= w_serve & ~r_owner_d;
            r_i_err  <= w_serve & ~r_owner_d & w_oor;
            r_d_done <= w_serve & r_owner_d;
            r_d_err  <= w_serve & r_owner_d & w_oor;
            if (w_serve && !r_owner_d) r_i_rdata <= w_rdata_cap;
            if (w_serve &&  r_owner_d) r_d_rdata <= w_rdata_cap;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The memory bus is only active in SERVE; since r_state is
    // asynchronously reset, a write in flight is cut off as rst rises.
    // ------------------------------------------------------------------
    assign bus.i_gnt   = w_i_gnt;
    assign bus.d_gnt   = w_d_gnt;
    assign bus.i_done  = r_i_done;
    assign bus.i_err   = r_i_err;
    assign bus.i_rdata = r_i_rdata;
    assign bus.d_done  = r_d_done;
    assign bus.d_err   = r_d_err;
    assign bus.d_rdata = r_d_rdata;

    assign bus.mem_A   = w_serve ? {r_word, 2'b00} : 32'd0;
    assign bus.mem_WD  = w_serve ? r_wdata : 32'd0;
    assign bus.mem_We  = w_serve & r_we & ~w_oor;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Directed accesses,
//               arbitration ordering for both priority modes, reset during
//               a store, then randomized traffic against a transaction-level
//               reference model with its own memory image.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int MEM_WORDS = 16000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if u_bus0 ();
    mem_arbiter_if u_bus1 ();

    mem_arbiter #(.MEM_WORDS(MEM_WORDS), .PRIO_MODE(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (u_bus0)
    );

    mem_arbiter #(.MEM_WORDS(MEM_WORDS), .PRIO_MODE(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u_bus1)
    );

    // ------------------------------------------------------------------
    // Memory behind dut0 (sync write, comb read); preloads go through poke.
    // ------------------------------------------------------------------
    logic [31:0] mem [0:MEM_WORDS-1];
    logic        poke_en  = 1'b0;
    int          poke_idx = 0;
    logic [31:0] poke_val = '0;

    always @(posedge clk) begin
        if (poke_en)
            mem[poke_idx] <= poke_val;
        else if (u_bus0.mem_We && (u_bus0.mem_A[31:2] < 30'(MEM_WORDS)))
            mem[u_bus0.mem_A[31:2]] <= u_bus0.mem_WD;
    end

    assign u_bus0.mem_RD = (u_bus0.mem_A[31:2] < 30'(MEM_WORDS)) ?
                           mem[u_bus0.mem_A[31:2]] : 32'hBAD0_BAD0;
    assign u_bus1.mem_RD = 32'h0;

    // Reference memory image for the random phase.
    logic [31:0] ref_mem [0:MEM_WORDS-1];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        @(posedge clk); #1;
        poke_en  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One directed access on dut0 started from IDLE, checked cycle by cycle.
    task automatic access(input string tag, input bit is_d, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input bit exp_err, input bit exp_we);
        if (is_d) begin
            u_bus0.d_req = 1'b1; u_bus0.d_we = we;
            u_bus0.d_addr = addr; u_bus0.d_wdata = wdata;
        end else begin
            u_bus0.i_req = 1'b1; u_bus0.i_addr = addr;
        end
        @(negedge clk);
        chk({tag, ".gnt"}, is_d ? u_bus0.d_gnt : u_bus0.i_gnt, 32'd1);
        @(posedge clk); #1;
        u_bus0.i_req = 1'b0; u_bus0.d_req = 1'b0; u_bus0.d_we = 1'b0;
        @(negedge clk);
        chk({tag, ".memA"},  u_bus0.mem_A, {addr[31:2], 2'b00});
        chk({tag, ".memWe"}, u_bus0.mem_We, 32'(exp_we));
        chk({tag, ".memWD"}, u_bus0.mem_WD, is_d ? wdata : 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, ".done"},  is_d ? u_bus0.d_done  : u_bus0.i_done, 32'd1);
        chk({tag, ".rdata"}, is_d ? u_bus0.d_rdata : u_bus0.i_rdata, exp_rd);
        chk({tag, ".err"},   is_d ? u_bus0.d_err   : u_bus0.i_err, 32'(exp_err));
        chk({tag, ".memWe_resp"}, u_bus0.mem_We, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, ".done_clr"}, is_d ? u_bus0.d_done : u_bus0.i_done, 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        int unsigned r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r < 7)       a = 32'($urandom_range(0, 15)) << 2;
        else if (r == 7) a = 32'(MEM_WORDS - 1) << 2;
        else if (r == 8) a = (32'(MEM_WORDS) + 32'($urandom_range(0, 3))) << 2;
        else             a = $urandom | 32'h8000_0000;
        a[1:0] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        u_bus0.i_req = 1'b1; u_bus0.i_addr = 32'h0;
        u_bus0.d_req = 1'b1; u_bus0.d_we = 1'b1;
        u_bus0.d_addr = 32'h0; u_bus0.d_wdata = 32'hFFFF_FFFF;
        u_bus1.i_req = 1'b0; u_bus1.i_addr = 32'h0;
        u_bus1.d_req = 1'b0; u_bus1.d_we = 1'b0;
        u_bus1.d_addr = 32'h0; u_bus1.d_wdata = 32'h0;

        // ---------------- reset state (requests held high) -------------
        @(negedge clk);
        chk("rst.i_gnt",  u_bus0.i_gnt, 0);
        chk("rst.d_gnt",  u_bus0.d_gnt, 0);
        chk("rst.i_done", u_bus0.i_done, 0);
        chk("rst.d_done", u_bus0.d_done, 0);
        chk("rst.i_rdata", u_bus0.i_rdata, 0);
        chk("rst.d_rdata", u_bus0.d_rdata, 0);
        chk("rst.i_err",  u_bus0.i_err, 0);
        chk("rst.d_err",  u_bus0.d_err, 0);
        chk("rst.memA",   u_bus0.mem_A, 0);
        chk("rst.memWD",  u_bus0.mem_WD, 0);
        chk("rst.memWe",  u_bus0.mem_We, 0);
        u_bus0.i_req = 1'b0; u_bus0.d_req = 1'b0; u_bus0.d_we = 1'b0;
        u_bus0.d_wdata = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;

        poke(0, 32'h0);
        poke(4, 32'hDEAD_BEEF);
        poke(8, 32'h0);
        poke(16, 32'h1111_1111);
        poke(MEM_WORDS - 1, 32'h5A5A_1234);

        // ---------------- directed accesses -----------------------------
        access("fetch",  0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 0);
        access("misal",  0, 0, 32'h13, 32'h0, 32'hDEAD_BEEF, 0, 0);
        access("store",  1, 1, 32'h20, 32'h1234_5678, 32'h0, 0, 1);
        chk("store.mem", mem[8], 32'h1234_5678);
        access("load",   1, 0, 32'h20, 32'hFFFF_FFFF, 32'h1234_5678, 0, 0);
        access("oor_st", 1, 1, 32'(MEM_WORDS) << 2, 32'hCAFE_F00D, 32'h0, 1, 0);
        access("last",   1, 0, 32'(MEM_WORDS - 1) << 2, 32'h0, 32'h5A5A_1234, 0, 0);
        chk("oor_st.mem", mem[MEM_WORDS - 1], 32'h5A5A_1234);
        access("oor_if", 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1, 0);

        // ---------------- reset during SERVE of a store -----------------
        u_bus0.d_req = 1'b1; u_bus0.d_we = 1'b1;
        u_bus0.d_addr = 32'h40; u_bus0.d_wdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("abort.gnt", u_bus0.d_gnt, 1);
        @(posedge clk); #1;
        u_bus0.d_req = 1'b0; u_bus0.d_we = 1'b0;
        @(negedge clk);
        chk("abort.memWe_pre", u_bus0.mem_We, 1);
        #1 rst = 1'b1;
        #1 chk("abort.memWe_async", u_bus0.mem_We, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort.no_done", u_bus0.d_done, 0);
        end
        chk("abort.mem",   mem[16], 32'h1111_1111);
        chk("abort.memA",  u_bus0.mem_A, 0);
        chk("abort.memWD", u_bus0.mem_WD, 0);
        chk("abort.rdata", u_bus0.d_rdata, 0);
        chk("abort.err",   u_bus0.d_err, 0);
        @(posedge clk); #1;

        // ---------------- arbitration order, both modes -----------------
        u_bus0.d_addr = 32'h0; u_bus0.i_addr = 32'h0;
        u_bus0.i_req = 1'b1; u_bus0.d_req = 1'b1;
        u_bus1.i_req = 1'b1; u_bus1.d_req = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            chk("rr.i_gnt", u_bus0.i_gnt, 32'(c < 12 && c % 6 == 0));
            chk("rr.d_gnt", u_bus0.d_gnt, 32'(c < 12 && c % 6 == 3));
            chk("fp.d_gnt", u_bus1.d_gnt, 32'(c < 12 && c % 3 == 0));
            chk("fp.i_gnt", u_bus1.i_gnt, 32'(c == 12));
            @(posedge clk); #1;
            if (c == 11) begin
                u_bus0.i_req = 1'b0; u_bus0.d_req = 1'b0;
                u_bus1.d_req = 1'b0;
            end
            if (c == 12) u_bus1.i_req = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;

        // ---------------- randomized traffic vs. model -------------------
        apply_reset();
        for (int w = 0; w < 17; w++) begin
            int idx;
            logic [31:0] v;
            idx = (w < 16) ? w : MEM_WORDS - 1;
            v = $urandom;
            poke(idx, v);
            ref_mem[idx] = v;
        end
        begin
            int due, busy;
            bit due_d, due_err, due_we, last_d, gi, gd, we, oor;
            logic [31:0] due_rd, a, wd, word;
            due = -10; busy = 0; last_d = 1'b1;
            due_d = 0; due_err = 0; due_we = 0; due_rd = 0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                @(negedge clk);
                gi = 0; gd = 0;
                if (busy == 0 && (u_bus0.i_req || u_bus0.d_req)) begin
                    if (u_bus0.i_req && u_bus0.d_req) gd = !last_d;
                    else                              gd = u_bus0.d_req;
                    gi = !gd;
                end
                chk("rnd.i_gnt", u_bus0.i_gnt, 32'(gi));
                chk("rnd.d_gnt", u_bus0.d_gnt, 32'(gd));
                chk("rnd.memWe", u_bus0.mem_We, 32'(cyc == due - 1 && due_we));
                chk("rnd.i_done", u_bus0.i_done, 32'(cyc == due && !due_d));
                chk("rnd.d_done", u_bus0.d_done, 32'(cyc == due && due_d));
                if (cyc == due) begin
                    chk("rnd.rdata", due_d ? u_bus0.d_rdata : u_bus0.i_rdata, due_rd);
                    chk("rnd.err",   due_d ? u_bus0.d_err   : u_bus0.i_err, 32'(due_err));
                end
                if (gi || gd) begin
                    a    = gd ? u_bus0.d_addr : u_bus0.i_addr;
                    we   = gd && u_bus0.d_we;
                    wd   = u_bus0.d_wdata;
                    word = a >> 2;
                    oor  = word >= 32'(MEM_WORDS);
                    if (we || oor) due_rd = 32'h0;
                    else           due_rd = ref_mem[word];
                    if (we && !oor) ref_mem[word] = wd;
                    due = cyc + 2; due_d = gd; due_err = oor;
                    due_we = we && !oor; busy = 2; last_d = gd;
                end else if (busy > 0) begin
                    busy--;
                end
                @(posedge clk); #1;
                if (gi || !u_bus0.i_req) begin
                    u_bus0.i_req  = ($urandom_range(0, 2) != 0);
                    u_bus0.i_addr = rnd_addr();
                end
                if (gd || !u_bus0.d_req) begin
                    u_bus0.d_req   = ($urandom_range(0, 2) != 0);
                    u_bus0.d_we    = 1'($urandom_range(0, 1));
                    u_bus0.d_addr  = rnd_addr();
                    u_bus0.d_wdata = $urandom;
                end
            end
        end
        u_bus0.i_req = 1'b0; u_bus0.d_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int w = 0; w < 17; w++) begin
            int idx;
            idx = (w < 16) ? w : MEM_WORDS - 1;
            chk("rnd.mem_image", mem[idx], ref_mem[idx]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared single-port word memory: synchronous write, combinational read, word index = A[31:2].
- Requester I is instruction fetch (read-only); requester D is load/store.
- The block grants one requester at a time, latches its request, and drives the memory for exactly one cycle.
- It returns registered read data with a one-cycle done pulse, and flags out-of-range addresses.

Parameters:
- MEM_WORDS, 16000: memory depth in 32-bit words; word index >= MEM_WORDS is out of range.
- PRIO_MODE, 0: 0 = round-robin between I and D; 1 = fixed priority, D always wins.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_req  input  1  fetch request; level, held until i_gnt.
- i_addr  input  32  fetch byte address; bits [1:0] ignored.
- i_gnt  output  1  combinational; request accepted at this clock edge.
- i_done  output  1  registered one-cycle pulse; response valid.
- i_rdata  output  32  fetched word; valid while i_done=1.
- i_err  output  1  out-of-range fetch; valid with i_done.
- d_req  input  1  data request; level, held until d_gnt.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  32  data byte address; bits [1:0] ignored.
- d_wdata  input  32  store data.
- d_gnt  output  1  combinational accept.
- d_done  output  1  registered one-cycle pulse.
- d_rdata  output  32  load word; valid while d_done=1; 0 for stores.
- d_err  output  1  out-of-range access; valid with d_done.
- mem_A  output  32  memory address.
- mem_WD  output  32  memory write data.
- mem_We  output  1  memory write enable.
- mem_RD  input  32  memory read data (combinational from mem_A).

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- On rst: state=IDLE, owner=none, last_winner=D (so I wins the first tie in round-robin).
- All outputs 0 on reset, including mem_A, mem_WD, mem_We, both *_done, *_rdata and *_err.
- States:
  - IDLE: memory bus idle (mem_A=0, mem_WD=0, mem_We=0).
  - SERVE: exactly one cycle; the latched access drives the memory.
  - RESP: exactly one cycle; the done pulse is high.
- IDLE transitions:
  - No request: remain in IDLE.
  - Any request: select a winner and assert its *_gnt combinationally in this cycle.
  - At the clock edge: latch the winner's addr, we and wdata (I: we=0), set owner, update last_winner, go to SERVE.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesting, PRIO_MODE=0: the requester that is not last_winner wins.
  - Both requesting, PRIO_MODE=1: D wins.
  - The loser's request stays pending and is never dropped.
- *_gnt is 0 in SERVE and RESP.
- A requester may change or deassert its request inputs in the cycle after gnt.
- SERVE, range check: out_of_range = addr_q[31:2] >= MEM_WORDS, computed unsigned on the full 30-bit index.
- SERVE, bus drive: mem_A = {addr_q[31:2], 2'b00}; mem_WD = wdata_q; mem_We = we_q & ~out_of_range.
- SERVE, at the clock edge:
  - Capture rdata = (we_q | out_of_range) ? 0 : mem_RD into the owner's *_rdata.
  - Set the owner's *_done=1 and *_err=out_of_range; go to RESP.
- RESP:
  - Memory bus idle; done and err held for this one cycle only.
  - At the clock edge: clear *_done and *_err, go to IDLE.
  - *_rdata holds its value until the next response to the same requester.
- Timing:
  - Latency: gnt edge N -> memory access in cycle N+1 -> done high in cycle N+2.
  - Throughput: one access per 3 cycles; a back-to-back request may be granted in cycle N+3.
- Requests arriving in SERVE or RESP wait; there is no queuing beyond the request level.
- Reset mid-operation:
  - A write in SERVE is aborted: mem_We falls to 0 asynchronously with rst.
  - No done is ever issued for an aborted access.
- The memory's address is word-aligned; misaligned low bits are silently ignored and never flagged.

Test Plan:
- Reset, then i_req=1, i_addr=0x10 with memory word 4 = 0xDEADBEEF -> i_gnt high in cycle 0; mem_A=0x10, mem_We=0 in cycle 1; i_done=1 with i_rdata=0xDEADBEEF in cycle 2; i_err=0.
- d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678 -> mem_We=1 only in the SERVE cycle; d_done=1, d_rdata=0. A following load from 0x20 returns 0x12345678.
- PRIO_MODE=0, both requests held continuously -> grants alternate I, D, I, D with the first grant to I, spaced 3 cycles apart; with PRIO_MODE=1, D wins every grant and I is never granted while d_req=1.
- d_we=1, d_addr=4*MEM_WORDS (0xFA00 at default) -> mem_We stays 0 in SERVE; d_done=1, d_err=1, d_rdata=0; memory contents unchanged.
- Assert rst during the SERVE cycle of a store -> mem_We drops immediately, no d_done pulse, the target word is unchanged, and the FSM returns to IDLE with all outputs 0.
- i_addr=0x13 (misaligned) -> mem_A=0x10; i_err=0; returns word 4.
